ram_bit_streamer: RTL

RAM_BIT_STREAMER -- requirements
Module: ram_bit_streamer

---
 rtl/ram_bit_streamer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ram_bit_streamer.sv
// ram_bit_streamer: packs bits read from a 1-bit registered-address RAM into words.
// Optional RAM_RD_WRAP_EN: read address wraps modulo 2**ADDR_W, every start accepted.
module ram_bit_streamer #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        len_words,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BC_W  = $clog2(WORD_W + 1);
  localparam int TOT_W = 8 + $clog2(WORD_W) + 1;
  localparam logic [BC_W-1:0] FULL = BC_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [TOT_W-1:0]  iss_q, iss_d;
  logic [TOT_W-1:0]  tot_q, tot_d;
  logic [7:0]        wleft_q, wleft_d;
  logic              a_vld_q, a_vld_d;
  logic              b_vld_q, b_vld_d;
  logic              hold_q, hold_d;
  logic              skid_q, skid_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_vld_q, out_vld_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic legal;
  logic stall;
  logic sr_full;
  logic acc;
  logic bit_in;

`ifdef RAM_RD_WRAP_EN
  assign legal = 1'b1;
`else
  logic [31:0] req_end;
  assign req_end = 32'(base_addr) + 32'(len_words) * 32'(WORD_W);
  assign legal   = req_end <= (32'd1 << ADDR_W);
`endif

  assign sr_full = cnt_q == FULL;
  assign acc     = out_vld_q && out_ready;
  // the bit parked in skid_q is the one lost from ram_q when a stall began
  assign bit_in  = hold_q ? skid_q : ram_q;

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    iss_d      = iss_q;
    tot_d      = tot_q;
    wleft_d    = wleft_q;
    a_vld_d    = a_vld_q;
    b_vld_d    = b_vld_q;
    hold_d     = hold_q;
    skid_d     = skid_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      IDLE: begin
        a_vld_d = 1'b0;
        b_vld_d = 1'b0;
        hold_d  = 1'b0;
        cnt_d   = '0;
        if (start) begin
          if (len_words == 8'd0) begin
            done_d = 1'b1;
          end else if (!legal) begin
            err_d = 1'b1;
          end else begin
            state_d    = PRIME;
            ram_addr_d = base_addr;
            iss_d      = TOT_W'(1);
            tot_d      = TOT_W'(len_words) * TOT_W'(WORD_W);
            wleft_d    = len_words;
            a_vld_d    = 1'b1;
          end
        end
      end

      PRIME, STREAM, DRAIN: begin
        stall = sr_full && out_vld_q && !out_ready;
        if (acc) begin
          out_vld_d = 1'b0;
          wleft_d   = wleft_q - 8'd1;
        end
        if (stall) begin
          if (!hold_q) begin
            skid_d = ram_q;
            hold_d = 1'b1;
          end
        end else begin
          hold_d  = 1'b0;
          b_vld_d = a_vld_q;
          a_vld_d = 1'b0;
          if (iss_q != tot_q) begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            iss_d      = iss_q + TOT_W'(1);
            a_vld_d    = 1'b1;
          end
          cnt_d = sr_full ? '0 : cnt_q;
          if (sr_full) begin
            out_data_d = sr_q;
            out_vld_d  = 1'b1;
          end
          if (b_vld_q) begin
            sr_d  = {sr_q[WORD_W-2:0], bit_in};
            cnt_d = cnt_d + BC_W'(1);
          end
        end

        if (state_q == PRIME) begin
          state_d = STREAM;
        end else if (state_q == STREAM && iss_q == tot_q) begin
          state_d = DRAIN;
        end
        if (acc && wleft_q == 8'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      iss_q      <= '0;
      tot_q      <= '0;
      wleft_q    <= '0;
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
      hold_q     <= 1'b0;
      skid_q     <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      iss_q      <= iss_d;
      tot_q      <= tot_d;
      wleft_q    <= wleft_d;
      a_vld_q    <= a_vld_d;
      b_vld_q    <= b_vld_d;
      hold_q     <= hold_d;
      skid_q     <= skid_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_vld_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign err       = err_q;

endmodule
